// File: rtl/fp_cmp_initiator.sv
// fp_cmp_initiator: issues IEEE 754 single-precision operand pairs to one
// comparator over the ready/data_valid/calc_done/read_done handshake and returns
// each 3-bit result through a one-entry valid/ready output buffer.
// Optional build macro: FP_CMP_TIMEOUT_EN adds a calc_done watchdog that aborts
// with out_result=000, out_err=1 after TIMEOUT_CYCLES waiting cycles.
module fp_cmp_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
    localparam int unsigned DATA_W        = 32,
    localparam int unsigned RES_W         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic              out_err,
    input  logic              cmp_ready,
    output logic              cmp_data_valid,
    input  logic              cmp_calc_done,
    output logic              cmp_read_done,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic [RES_W-1:0]  cmp_result
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t state;
    logic   buf_free_c;

`ifdef FP_CMP_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^CNT_W'(TIMEOUT_CYCLES);
`endif

    // Buffer can take a result if empty or being drained this cycle.
    assign buf_free_c = !out_valid || out_ready;

    // Handshake FSM with registered outputs and the one-entry result buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            in_ready       <= 1'b1;
            cmp_data_valid <= 1'b0;
            cmp_read_done  <= 1'b0;
            cmp_a          <= '0;
            cmp_b          <= '0;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_err        <= 1'b0;
`ifdef FP_CMP_TIMEOUT_EN
            cnt            <= '0;
`endif
        end else begin
            cmp_data_valid <= 1'b0;
            cmp_read_done  <= 1'b0;
            // Pop; a load later in this block overrides it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cmp_a    <= in_a;
                        cmp_b    <= in_b;
                        in_ready <= 1'b0;
                        state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (cmp_ready) begin
                        cmp_data_valid <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // cmp_ready lags data_valid by a cycle, so it is not re-checked.
`ifdef FP_CMP_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmp_calc_done && buf_free_c) begin
                        out_result    <= cmp_result;
                        out_err       <= 1'b0;
                        out_valid     <= 1'b1;
                        cmp_read_done <= 1'b1;
                        state         <= ST_ACK;
                    end
`ifdef FP_CMP_TIMEOUT_EN
                    else if (!cmp_calc_done) begin
                        if (cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            // Saturate; abort as soon as the buffer frees up.
                            cnt <= CNT_W'(TIMEOUT_CYCLES);
                            if (buf_free_c) begin
                                out_result    <= '0;
                                out_err       <= 1'b1;
                                out_valid     <= 1'b1;
                                cmp_read_done <= 1'b1;
                                state         <= ST_ACK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_ACK: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_cmp_initiator.md
# fp_cmp_initiator

Initiator for the floating-point comparator handshake (ready / data_valid / calc_done / read_done). It accepts IEEE 754 single-precision operand pairs on a valid/ready stream and issues each pair to one comparator instance. It collects each 3-bit result and returns it on a valid/ready result stream with a one-entry output buffer. The block sits between the render pipeline's compare requesters (depth test, min/max reduction) and the comparator.

## Interface
- TIMEOUT_CYCLES, 64: max cycles waited for cmp_calc_done before abort (used only with FP_CMP_TIMEOUT_EN).
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width.

- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair available.
- in_ready  out  1  block accepts pair this cycle.
- in_a, in_b  in  32  operands.
- out_valid  out  1  result buffer full.
- out_ready  in  1  consumer takes result this cycle.
- out_result  out  3  100 a>b, 010 a=b, 001 a<b, 000 unordered (NaN) or aborted.
- out_err  out  1  result is a timeout abort.
- cmp_ready  in  1  comparator idle.
- cmp_data_valid  out  1  one-cycle issue strobe.
- cmp_calc_done  in  1  comparator result valid.
- cmp_read_done  out  1  one-cycle result acknowledge.
- cmp_a, cmp_b  out  32  operands to the comparator, held from accept until acknowledge.
- cmp_result  in  3  comparator result.

## Operation
- Reset values:
  - State IDLE.
  - in_ready=1, because it decodes IDLE.
  - cmp_data_valid=0, cmp_read_done=0.
  - cmp_a=cmp_b=0.
  - out_valid=0, out_result=000, out_err=0.
  - Counter 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, register in_a/in_b into cmp_a/cmp_b and go to ARM.
  - ARM: wait for cmp_ready=1, then go to ISSUE.
  - ISSUE: cmp_data_valid=1 for exactly one cycle, then go to WAIT. cmp_ready is not re-checked after ISSUE, because it falls one cycle late.
  - WAIT: wait for cmp_calc_done=1 and a free buffer. The buffer is free when out_valid=0, or out_valid=1 and out_ready=1 in the same cycle. When both hold, load out_result<=cmp_result, set out_valid<=1 and out_err<=0, then go to ACK.
  - ACK: cmp_read_done=1 for exactly one cycle, then go to IDLE.
- Backpressure: if calc_done=1 but the buffer is full, stay in WAIT with read_done=0. The comparator then holds calc_done and result.
- cmp_a/cmp_b stay stable from the accept edge through ACK. The comparator samples the operands during its compare cycle and does not latch them.
- Output buffer:
  - out_valid clears on out_valid & out_ready unless reloaded in the same cycle.
  - Simultaneous pop and load: the new result wins and out_valid stays 1.
- No operand inspection in this block. NaN yields 000 with out_err=0.
- Only one request is outstanding at a time. in_ready=0 outside IDLE.

## Timing
- Counted from the accept cycle as cycle 0, with out_ready=1 and the comparator idle:
  - Cycle 1: ARM.
  - Cycle 2: ISSUE, data_valid=1.
  - Cycle 3: comparator compares.
  - Cycle 4: comparator done state, calc_done still 0.
  - Cycle 5: calc_done=1, result captured at end of cycle.
  - Cycle 6: ACK, read_done=1, out_valid=1.
  - Cycle 7: IDLE, in_ready=1.
- Next accept: cycle 7. Comparator ready returns at cycle 8, so the next ISSUE is at cycle 9. Throughput is one pair per 7 cycles.
- calc_done has dropped by cycle 7, so a stale calc_done is never seen in WAIT.
- Reset mid-operation: all outputs return to reset values asynchronously and any in-flight pair is discarded. The comparator shares rst_n.

## Configuration
- FP_CMP_TIMEOUT_EN defined:
  - The counter increments in WAIT while cmp_calc_done=0 and clears on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES with the buffer free: load out_result=000 and out_err=1, set out_valid=1, and go to ACK. read_done is pulsed to recover the comparator.
  - If the buffer is full at that point, stay in WAIT with the counter saturated until the buffer is free.
- FP_CMP_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; out_err tied 0.

## Test plan
- 1.0 vs 2.0 (a=0x3F800000, b=0x40000000) -> out_result=001 and out_valid at cycle 6. Exactly one data_valid pulse and one read_done pulse.
- a=0x00000000, b=0x80000000 -> 010; a=0xC0000000, b=0xBF800000 -> 001; a=0x40400000, b=0xC0400000 -> 100. Sent back-to-back, accepts at cycles 0, 7, 14.
- out_ready=0 with the first result pending, then a second pair sent -> master holds WAIT and read_done stays 0 while calc_done=1. Raising out_ready -> second result loaded in the same cycle as the pop.
- a=0x7FC00000, b=0x3F800000 -> out_result=000, out_err=0.
- Stub comparator that never asserts calc_done:
  - With FP_CMP_TIMEOUT_EN: out_valid at ISSUE+1+64 cycles with out_result=000, out_err=1, then a read_done pulse.
  - Without it: out_valid stays 0.
- rst_n low during WAIT -> in_ready=1, out_valid=0, cmp_data_valid=0, cmp_read_done=0 immediately. A fresh pair after release completes normally.
